// File: rtl/divider_32bit.sv
// Unsigned restoring divider: one quotient bit per cycle, done pulses WIDTH+1 cycles after start (1 cycle for b=0).
// start is only honoured in IDLE; requests while busy or done are dropped, never queued.
module divider_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   t;
  logic             carry;
  logic [WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             t_msb_unused;

  // Trial subtraction P' - D as an add of the complement; carry-out means no borrow.
  assign p_shift = {p_reg, q_reg[WIDTH-1]};
  assign {carry, t} = {1'b0, p_shift} + {1'b0, ~{1'b0, d_reg}} + (WIDTH + 2)'(1);

  // When the subtraction is kept, T < D, so its top bit is always zero.
  assign t_msb_unused = t[WIDTH];

  assign p_nxt = carry ? t[WIDTH-1:0] : p_shift[WIDTH-1:0];
  assign q_nxt = {q_reg[WIDTH-2:0], carry};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (b == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Result registers load only on entry to DONE so they stay put while iterating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            p_reg       <= '0;
            q_reg       <= a;
            d_reg       <= b;
            cnt         <= '0;
            div_by_zero <= (b == '0);
            if (b == '0) begin
              quotient  <= '1;
              remainder <= a;
            end
          end
        end
        RUN: begin
          p_reg <= p_nxt;
          q_reg <= q_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            quotient  <= q_nxt;
            remainder <= p_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_32bit.sv
// Bench for divider_32bit: directed vector table, hand-written corner sequences and random operands vs. a/b, a%b.
module tb_divider_32bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks;
  int failures;
  logic [31:0] prev_q;
  logic [31:0] prev_r;

  divider_32bit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] mq, output logic [31:0] mr, output logic mdz);
    if (mb == 32'd0) begin
      mq  = 32'hFFFF_FFFF;
      mr  = ma;
      mdz = 1'b1;
    end else begin
      mq  = ma / mb;
      mr  = ma % mb;
      mdz = 1'b0;
    end
  endtask

  // One operation from IDLE; inject > 0 pulses start with 9/3 in that cycle after acceptance.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] eq,
                       input logic [31:0] er, input logic edz, input int inject, input string nm);
    int  lat;
    int  busy_cnt;
    bit  stable;
    bit  seen;
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb;
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    stable   = 1'b1;
    seen     = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = cyc;
      end else begin
        if (busy) busy_cnt++;
        if (quotient !== prev_q || remainder !== prev_r) stable = 1'b0;
        if (cyc == inject) begin
          start = 1'b1;
          a     = 32'd9;
          b     = 32'd3;
        end else begin
          start = 1'b0;
          a     = $urandom;
          b     = $urandom;
        end
      end
    end
    start = 1'b0;
    check({nm, " latency"}, lat, (tb == 32'd0) ? 32'd1 : 32'd33);
    check({nm, " busy_cycles"}, busy_cnt, (tb == 32'd0) ? 32'd0 : 32'd32);
    check({nm, " quotient"}, quotient, eq);
    check({nm, " remainder"}, remainder, er);
    check({nm, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
    check({nm, " held_during_run"}, {31'd0, stable}, 32'd1);
    @(negedge clk);
    check({nm, " done_pulse_width"}, {31'd0, done}, 32'd0);
    check({nm, " hold_quotient"}, quotient, eq);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    vec_t vecs[8];
    logic [31:0] ra, rb, mq, mr;
    logic        mdz;
    int          t1, t2;
    bit          fin;

    checks   = 0;
    failures = 0;
    prev_q   = '0;
    prev_r   = '0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,  1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,  1'b0};
    vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,  1'b0};
    vecs[3] = '{32'd7,          32'd9,          32'd0,          32'd7,  1'b0};
    vecs[4] = '{32'd0,          32'd5,          32'd0,          32'd0,  1'b0};
    vecs[5] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,  1'b1};
    vecs[6] = '{32'd1000,       32'd10,         32'd100,        32'd0,  1'b0};
    vecs[7] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,  1'b0};

    repeat (2) @(negedge clk);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].eq, vecs[i].er, vecs[i].edz, 0, $sformatf("vec%0d", i));
    end

    // start pulsed mid-RUN with new operands must be ignored
    do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10, "ignore_start_run");

    // start during DONE must not be queued
    @(negedge clk);
    start = 1'b1;
    a     = 32'd5;
    b     = 32'd0;
    @(negedge clk);
    check("dz done_next_cycle", {31'd0, done}, 32'd1);
    a = 32'd9;
    b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("dz idle_busy", {31'd0, busy}, 32'd0);
    check("dz idle_done", {31'd0, done}, 32'd0);
    check("dz quotient", quotient, 32'hFFFF_FFFF);
    @(negedge clk);
    check("no_queue busy", {31'd0, busy}, 32'd0);
    check("no_queue done", {31'd0, done}, 32'd0);
    prev_q = 32'hFFFF_FFFF;
    prev_r = 32'd5;

    // start held high: back-to-back operations every 34 cycles
    @(negedge clk);
    start = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    a   = 32'd50;
    b   = 32'd6;
    t1  = 0;
    t2  = 0;
    fin = 1'b0;
    for (int cyc = 1; cyc <= 80 && !fin; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (done) begin
        if (t1 == 0) begin
          t1 = cyc;
          check("b2b first quotient", quotient, 32'd14);
          check("b2b first remainder", remainder, 32'd2);
        end else begin
          t2    = cyc;
          start = 1'b0;
          fin   = 1'b1;
          check("b2b second quotient", quotient, 32'd8);
          check("b2b second remainder", remainder, 32'd2);
        end
      end
    end
    start = 1'b0;
    check("b2b first latency", t1, 32'd33);
    check("b2b spacing", t2 - t1, 32'd34);
    @(negedge clk);
    check("b2b stop busy", {31'd0, busy}, 32'd0);
    prev_q = 32'd8;
    prev_r = 32'd2;

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst quotient", quotient, 32'd0);
    check("async_rst remainder", remainder, 32'd0);
    check("async_rst busy", {31'd0, busy}, 32'd0);
    check("async_rst done", {31'd0, done}, 32'd0);
    check("async_rst div_by_zero", {31'd0, div_by_zero}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("in_rst done", {31'd0, done}, 32'd0);
    end
    rst    = 1'b0;
    prev_q = '0;
    prev_r = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) check("aborted op done", {31'd0, done}, 32'd0);
    end
    check("post_rst idle done", {31'd0, done}, 32'd0);
    do_op(32'd50, 32'd6, 32'd8, 32'd2, 1'b0, 0, "post_rst");

    // random operands against plain-arithmetic model
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 255);
        3:       rb = ra + $urandom_range(0, 3);
        4:       rb = ra >> $urandom_range(1, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = $urandom_range(0, 15);
      model(ra, rb, mq, mr, mdz);
      do_op(ra, rb, mq, mr, mdz, 0, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
